// File: rtl/pri_dec_3to8_pulse_if.sv
`default_nettype none
// ============================================================================
// Module      : pri_dec_3to8_pulse_if
// Description : Index handshake and one-hot output bundle for the 3-to-8
//               pulse decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface pri_dec_3to8_pulse_if;
    logic in_valid;
    logic a2;
    logic a1;
    logic a0;
    logic in_ready;
    logic y0;
    logic y1;
    logic y2;
    logic y3;
    logic y4;
    logic y5;
    logic y6;
    logic y7;
    logic busy;
    logic done;

    modport master (
        output in_valid, a2, a1, a0,
        input  in_ready, y0, y1, y2, y3, y4, y5, y6, y7, busy, done
    );

    modport slave (
        input  in_valid, a2, a1, a0,
        output in_ready, y0, y1, y2, y3, y4, y5, y6, y7, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pri_dec_3to8_pulse.sv
`default_nettype none
// ============================================================================
// Module      : pri_dec_3to8_pulse
// Description : Accepts a 3-bit index, holds the selected one-hot line for
//               HOLD_CYCLES, then forces an all-zero gap before the next index.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_dec_3to8_pulse #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pri_dec_3to8_pulse_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic             c_has_gap   = (GAP_CYCLES > 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_y;
    logic [7:0]       w_y_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [2:0]       w_a;
    logic             w_ready;
    logic             w_xfer;

    assign w_a     = {bus.a2, bus.a1, bus.a0};
    assign w_ready = (r_state == ST_IDLE) && !rst;
    assign w_xfer  = bus.in_valid && w_ready;

    // Next y is computed alongside next state so the line is registered and
    // rises in the very cycle HOLD begins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_y_nxt     = 8'h00;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_idx_nxt   = w_a;
                    w_cnt_nxt   = c_hold_load;
                    w_y_nxt     = 8'h01 << w_a;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    w_y_nxt   = 8'h01 << r_idx;
                end else begin
                    w_done_nxt = 1'b1;
                    if (c_has_gap) begin
                        w_cnt_nxt   = c_gap_load;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_y     <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_y     <= w_y_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
    assign bus.y0       = r_y[0];
    assign bus.y1       = r_y[1];
    assign bus.y2       = r_y[2];
    assign bus.y3       = r_y[3];
    assign bus.y4       = r_y[4];
    assign bus.y5       = r_y[5];
    assign bus.y6       = r_y[6];
    assign bus.y7       = r_y[7];

endmodule
`default_nettype wire

// File: tb/tb_pri_dec_3to8_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_pri_dec_3to8_pulse
// Description : Self-checking bench; two decoder instances (4/1 and 1/0
//               timing) against a cycle-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pri_dec_3to8_pulse;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit         v_drv [2];
    logic [2:0] a_drv [2];

    // Reference schedule per instance: pulse start, done cycle, ready cycle.
    int m_ps   [2] = '{-1000, -1000};
    int m_done [2] = '{-1000, -1000};
    int m_free [2] = '{0, 0};
    int m_idx  [2] = '{0, 0};
    int hc     [2] = '{4, 1};
    int gc     [2] = '{1, 0};

    pri_dec_3to8_pulse_if bus0 ();
    pri_dec_3to8_pulse_if bus1 ();

    assign bus0.in_valid = v_drv[0];
    assign {bus0.a2, bus0.a1, bus0.a0} = a_drv[0];
    assign bus1.in_valid = v_drv[1];
    assign {bus1.a2, bus1.a1, bus1.a0} = a_drv[1];

    pri_dec_3to8_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pri_dec_3to8_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Packed view {y7..y0, in_ready, busy, done}
    function automatic logic [10:0] obs(int d);
        if (d == 0)
            return {bus0.y7, bus0.y6, bus0.y5, bus0.y4, bus0.y3, bus0.y2, bus0.y1, bus0.y0,
                    bus0.in_ready, bus0.busy, bus0.done};
        return {bus1.y7, bus1.y6, bus1.y5, bus1.y4, bus1.y3, bus1.y2, bus1.y1, bus1.y0,
                bus1.in_ready, bus1.busy, bus1.done};
    endfunction

    function automatic logic [10:0] exp_o(int d);
        logic [7:0] y;
        logic       r;
        logic       b;
        logic       dn;
        y = 8'h00;
        if (cyc >= m_ps[d] && cyc < m_ps[d] + hc[d])
            y = 8'(1 << m_idx[d]);
        dn = (cyc == m_done[d]);
        b  = (cyc >= m_ps[d]) && (cyc < m_free[d]);
        r  = (cyc >= m_free[d]) && !rst;
        return {y, r, b, dn};
    endfunction

    task automatic set_in(int d, bit v, logic [2:0] a);
        v_drv[d] = v;
        a_drv[d] = a;
    endtask

    // Advance one edge and update the model from the inputs seen at that edge.
    task automatic step();
        bit         take [2];
        logic [2:0] ta   [2];
        bit         r;
        r = rst;
        for (int d = 0; d < 2; d++) begin
            take[d] = v_drv[d] && (cyc >= m_free[d]) && !r;
            ta[d]   = a_drv[d];
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_ps[d]   = -1000;
                m_done[d] = -1000;
                m_free[d] = cyc;
            end else if (take[d]) begin
                m_ps[d]   = cyc;
                m_idx[d]  = int'(ta[d]);
                m_done[d] = cyc + hc[d];
                m_free[d] = cyc + hc[d] + gc[d];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(0, 1'b1, 3'(($urandom) % 8));
        set_in(1, 1'b1, 3'(($urandom) % 8));
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== 11'b0) begin
                bad++;
                $display("FAIL reset_held d%0d got=%b exp=%b", d, obs(d), 11'b0);
            end
        end
        set_in(0, 1'b0, 3'd0);
        set_in(1, 1'b0, 3'd0);
        rst = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== 11'b000_0000_0100) begin
                    bad++;
                    $display("FAIL reset_idle d%0d got=%b exp=%b", d, obs(d), 11'b000_0000_0100);
                end
            end
            step();
        end
    endtask

    task automatic test_index5();
        int         k;
        int         rel;
        logic [7:0] ey;
        logic [10:0] o;
        set_in(0, 1'b1, 3'd5);
        step();
        k = cyc;
        for (int n = 0; n < 8; n++) begin
            set_in(0, 1'b0, 3'(($urandom) % 8));
            rel = cyc - k;
            ey  = (rel < 4) ? 8'h20 : 8'h00;
            o   = obs(0);
            total++;
            if (o[10:3] !== ey || o[0] !== (rel == 4) || o[2] !== (rel >= 5)) begin
                bad++;
                $display("FAIL index5 rel=%0d got=%b exp_y=%h done=%0d ready=%0d",
                         rel, o, ey, (rel == 4), (rel >= 5));
            end
            total++;
            if (o !== exp_o(0)) begin
                bad++;
                $display("FAIL index5_model rel=%0d got=%b exp=%b", rel, o, exp_o(0));
            end
            step();
        end
    endtask

    task automatic test_sweep();
        int          i;
        int          cnt [8];
        bit          x;
        logic [10:0] o;
        for (int n = 0; n < 8; n++) cnt[n] = 0;
        i = 0;
        set_in(0, 1'b1, 3'd0);
        for (int n = 0; n < 80 && i < 8; n++) begin
            x = bus0.in_ready;
            step();
            if (x) i++;
            set_in(0, (i < 8), 3'(i % 8));
            o = obs(0);
            for (int b = 0; b < 8; b++) cnt[b] += int'(o[3+b]);
            total++;
            if (o !== exp_o(0)) begin
                bad++;
                $display("FAIL sweep cyc=%0d got=%b exp=%b", cyc, o, exp_o(0));
            end
        end
        total++;
        if (i != 8) begin
            bad++;
            $display("FAIL sweep_timeout accepted=%0d exp=8", i);
        end
        for (int n = 0; n < 6; n++) begin
            step();
            o = obs(0);
            for (int b = 0; b < 8; b++) cnt[b] += int'(o[3+b]);
        end
        for (int b = 0; b < 8; b++) begin
            total++;
            if (cnt[b] != 4) begin
                bad++;
                $display("FAIL sweep_hold y%0d high=%0d exp=4", b, cnt[b]);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 1'b1, 3'd3);
        step();
        set_in(0, 1'b0, 3'd0);
        step();
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (obs(d) !== exp_o(d) || obs(d) !== 11'b0) begin
                bad++;
                $display("FAIL reset_mid_hold d%0d got=%b exp=%b", d, obs(d), 11'b0);
            end
        end
        rst = 1'b0;
        #1;
        for (int n = 0; n < 7; n++) begin
            total++;
            if (obs(0) !== exp_o(0) || bus0.done !== 1'b0 || bus0.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid_after n=%0d got=%b exp=%b", n, obs(0), exp_o(0));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        logic [10:0] o;
        seq[0] = 8'h80;
        seq[1] = 8'h00;
        seq[2] = 8'h04;
        seq[3] = 8'h00;
        set_in(1, 1'b1, 3'd7);
        for (int n = 0; n < 4; n++) begin
            step();
            if (n == 0) set_in(1, 1'b1, 3'd2);
            if (n == 2) set_in(1, 1'b0, 3'd0);
            o = obs(1);
            total++;
            if (o[10:3] !== seq[n] || o !== exp_o(1)) begin
                bad++;
                $display("FAIL back_to_back n=%0d got=%b exp_y=%h model=%b", n, o, seq[n], exp_o(1));
            end
        end
    endtask

    task automatic test_ignore_busy();
        int          c1;
        int          c6;
        logic [10:0] o;
        c1 = 0;
        c6 = 0;
        set_in(0, 1'b1, 3'd6);
        for (int n = 0; n < 10; n++) begin
            step();
            set_in(0, (n == 1), (n == 1) ? 3'd1 : 3'd0);
            o = obs(0);
            c1 += int'(o[4]);
            c6 += int'(o[9]);
            total++;
            if (o !== exp_o(0)) begin
                bad++;
                $display("FAIL ignore_busy n=%0d got=%b exp=%b", n, o, exp_o(0));
            end
        end
        total++;
        if (c1 != 0 || c6 != 4) begin
            bad++;
            $display("FAIL ignore_busy_count y1=%0d exp=0 y6=%0d exp=4", c1, c6);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(0, 1'(($urandom) % 2), 3'(($urandom) % 8));
            set_in(1, 1'(($urandom) % 2), 3'(($urandom) % 8));
            rst = (($urandom) % 50) == 0;
            step();
            for (int d = 0; d < 2; d++) begin
                total++;
                if (obs(d) !== exp_o(d)) begin
                    bad++;
                    $display("FAIL random d%0d cyc=%0d got=%b exp=%b", d, cyc, obs(d), exp_o(d));
                end
            end
        end
        rst = 1'b0;
        set_in(0, 1'b0, 3'd0);
        set_in(1, 1'b0, 3'd0);
    endtask

    initial begin
        v_drv[0] = 1'b0;
        v_drv[1] = 1'b0;
        a_drv[0] = 3'd0;
        a_drv[1] = 3'd0;
        test_reset();
        test_index5();
        test_sweep();
        test_reset_mid();
        test_back_to_back();
        test_ignore_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
